imem_loader: RTL
================

# imem_loader

Boot-time instruction-memory loader for the single-cycle MIPS core. It is the writer side of the instruction-memory port that the core only reads. It accepts a big-endian byte stream over a valid/ready handshake, packs it into 32-bit instructions, and writes them to sequential word addresses of a writable instruction memory. It holds the core in reset until the image is loaded and its checksum verifies.

## Interface
Parameters:
- ADDR_WIDTH, 6: instruction-memory word-address width; depth is 2**ADDR_WIDTH words.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  load request; sampled only in IDLE, DONE or ERROR.
- word_count  in  ADDR_WIDTH+1  number of words to load; sampled when start is accepted.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_WIDTH  word address.
- imem_wd  out  32  instruction word.
- cpu_rst  out  1  reset to the core; low only in DONE.
- busy  out  1  high in LOAD or CHECK.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.

## Operation
- **States:** IDLE, LOAD, CHECK, DONE, ERROR.
- **Reset values:** state=IDLE, cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wd=0, busy=0, done=0, error=0. Byte index, word index and checksum accumulator are all 0.
- **Byte acceptance:** a byte is accepted on a rising edge with in_valid && in_ready. in_ready=1 exactly in LOAD and CHECK.
- **IDLE / DONE / ERROR on start=1:**
  - word_count > 2**ADDR_WIDTH: go to ERROR.
  - word_count == 0: go to CHECK.
  - otherwise: go to LOAD.
  - In every case clear the byte index, word index and checksum, and drive cpu_rst=1 from the next cycle.
- **start while busy:** ignored in LOAD and CHECK.
- **LOAD:**
  - Each accepted byte shifts into the word register; the first byte becomes bits [31:24].
  - Each accepted byte adds into the 8-bit checksum, modulo 256.
  - On the 4th byte of a word, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wd = the packed word. The word index then increments.
  - When the 4th byte of word word_count-1 is accepted, go to CHECK on the same edge. That final write strobe appears during the first CHECK cycle.
- **CHECK:**
  - The next accepted byte is the checksum.
  - If it equals the accumulator, go to DONE; otherwise go to ERROR.
  - No memory write results from this byte.
- **DONE:** cpu_rst=0, done=1.
- **ERROR:** cpu_rst=1, error=1. Stays here until start or rst.
- **Memory contents:** never cleared by the loader. A failed or aborted load leaves partial contents in memory, but the core stays in reset.
- **Reset mid-load:** immediate return to IDLE. A partial word is discarded and any pending imem_we is dropped.
- **Address wrap:** the word index never exceeds word_count-1, so no wrap is possible.

## Timing
- Throughput: one byte per cycle; in_ready does not drop inside LOAD or CHECK.
- in_ready, busy, done, error and cpu_rst decode registered state only; there is no combinational path from in_valid.
- imem_we, imem_addr and imem_wd are registered and change together.
- Write latency: 1 cycle after the edge that accepts a word's 4th byte.
- An N-word load needs at least 4N+1 accepted bytes. done and cpu_rst=0 appear 1 cycle after the edge that accepts the checksum.
- After rst deasserts, the first start is honoured on the next rising edge.

## Structure
- **Shared package mips_pkg:**
  - loader state enum (IDLE, LOAD, CHECK, DONE, ERROR).
  - constant for the 4 bytes per word.
  - the instruction width (32).
- **Sub-module byte_packer:**
  - 8-bit in, 32-bit out, big-endian shift.
  - 2-bit byte index; pulses word_valid on the 4th byte.
  - clear input driven by the FSM.
- The FSM, word index and checksum live in imem_loader.

## Test plan
- **Two-word load:** word_count=2, bytes 20 08 00 05 AC 08 00 00, checksum E1.
  - Writes: addr 0 = 0x20080005, addr 1 = 0xAC080000.
  - Then done=1 and cpu_rst=0 one cycle after E1 is accepted.
- **Bad checksum:** same stream with checksum E0 gives error=1 and cpu_rst=1; both writes still occur.
- **Zero and oversized counts:**
  - word_count=0 with checksum 00 gives DONE with no imem_we.
  - word_count=2**ADDR_WIDTH+1 gives ERROR the next cycle with no writes.
- **Gapped and ignored inputs:**
  - Toggle in_valid every other cycle during a 3-word load; the written words match a gap-free run.
  - start pulsed during LOAD has no effect.
- **Reset and reload:**
  - Assert rst after 6 bytes: IDLE, cpu_rst=1, no further writes.
  - A following full load succeeds.
- **Reload from DONE:** start in DONE raises cpu_rst the next cycle and reloads from addr 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: loader states,
// word geometry and the running-checksum helper.
package mips_pkg;

  localparam int INSTR_WIDTH    = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  // 8-bit additive checksum, wrapping modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: the first byte of a word lands in [31:24];
// word_valid flags the byte that completes a word, with word showing the result.
module byte_packer
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_idx;
  logic [23:0] shift;

  // Byte index and the three already-received bytes of the current word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= 2'd0;
      shift    <= 24'd0;
    end else if (clear) begin
      byte_idx <= 2'd0;
      shift    <= 24'd0;
    end else if (in_valid) begin
      byte_idx <= byte_idx + 2'd1;
      shift    <= {shift[15:0], in_data};
    end else begin
      byte_idx <= byte_idx;
      shift    <= shift;
    end
  end

  assign word_valid = in_valid && (byte_idx == LAST_IDX);
  assign word       = {shift, in_data};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a checksummed byte stream into
// sequential instruction words and holds the core in reset until it verifies.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    word_count,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wd,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int              CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0]   ONE   = CW'(1);

  loader_state_t state, next_state;

  logic [CW-1:0]          word_idx;
  logic [CW-1:0]          last_idx;
  logic [7:0]             csum;
  logic                   accept;
  logic                   load_start;
  logic                   pack_accept;
  logic                   word_valid;
  logic [INSTR_WIDTH-1:0] packed_word;

  // Handshake and status decode from the registered state only.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_rst  = 1'b1;
    case (state)
      LOAD, CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
      end
      ERROR:   error = 1'b1;
      default: cpu_rst = 1'b1;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign pack_accept = accept && (state == LOAD);
  assign load_start  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_start),
    .in_valid   (pack_accept),
    .in_data    (in_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          if (word_count > DEPTH) begin
            next_state = ERROR;
          end else if (word_count == '0) begin
            next_state = CHECK;
          end else begin
            next_state = LOAD;
          end
        end else begin
          next_state = state;
        end
      end
      LOAD: begin
        if (word_valid && (word_idx == last_idx)) begin
          next_state = CHECK;
        end else begin
          next_state = state;
        end
      end
      CHECK: begin
        if (accept) begin
          next_state = (in_data == csum) ? DONE : ERROR;
        end else begin
          next_state = state;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Word index, last-word marker and running checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx <= '0;
      last_idx <= '0;
      csum     <= 8'd0;
    end else if (load_start) begin
      word_idx <= '0;
      last_idx <= word_count - ONE;
      csum     <= 8'd0;
    end else if (pack_accept) begin
      csum     <= csum_add(csum, in_data);
      word_idx <= word_valid ? (word_idx + ONE) : word_idx;
    end else begin
      word_idx <= word_idx;
      csum     <= csum;
    end
  end

  // Registered memory write port; address and data only move with a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= '0;
    end else if (word_valid) begin
      imem_we   <= 1'b1;
      imem_addr <= word_idx[ADDR_WIDTH-1:0];
      imem_wd   <= packed_word;
    end else begin
      imem_we   <= 1'b0;
    end
  end

endmodule
